// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: reset / NMI / IRQ / BRK entry sequencer for the 6502 core.
// Pushes PCH, PCL and PSR through the memory port, fetches the 16-bit vector
// and loads it into PC through the intr_* register-file strobes, holding the
// core stalled via intr_busy while a sequence runs.
// Build option: INTR_NMI_HIJACK_EN -- a pending NMI seen when a BRK/IRQ
// sequence enters VEC_LO redirects that sequence to the NMI vector.
module interrupt_sequencer (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        nmi,
  input  logic        irq,
  input  logic        exec_brk,
  input  logic        exec_boundary,
  input  logic [15:0] rf_pc,
  input  logic [7:0]  rf_psr,
  input  logic [7:0]  rf_s,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [7:0]  intr_data,
  output logic        intr_set_pcl,
  output logic        intr_set_pch,
  output logic        intr_set_i,
  output logic        intr_set_b,
  output logic        intr_pushed,
  output logic        intr_busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_PSR,
    ST_VEC_LO,
    ST_VEC_HI
  } state_t;

  typedef enum logic [1:0] {
    SRC_RST,
    SRC_NMI,
    SRC_IRQ,
    SRC_BRK
  } src_t;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  state_t      state_reg, state_next;
  src_t        src_reg, src_next;
  logic [15:0] vec_reg, vec_next;
  logic        rst_pend_reg, rst_pend_next;
  logic        nmi_pend_reg, nmi_pend_next;
  logic        set_b_reg, set_b_next;
  logic        nmi_prev_reg;
  logic        nmi_rise;
  logic        is_brk;
  logic [7:0]  psr_push;

  assign nmi_rise = nmi & ~nmi_prev_reg;
  assign is_brk   = (src_reg == SRC_BRK);

  // Pushed status byte: bit 5 always reads as 1, bit 4 (B) marks a BRK entry.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_psr_push
      if (gi == 5) begin : g_one
        assign psr_push[gi] = 1'b1;
      end else if (gi == 4) begin : g_brk
        assign psr_push[gi] = rf_psr[gi] | is_brk;
      end else begin : g_pass
        assign psr_push[gi] = rf_psr[gi];
      end
    end
  endgenerate

  // NMI input sampler for edge detection; tracks the pin even during reset so
  // a level held across reset release is not mistaken for a new edge.
  always_ff @(posedge clk) begin
    nmi_prev_reg <= nmi;
  end

  // Sequencer state; reset parks in IDLE with a reset fetch pending.
  always_ff @(posedge clk) begin
    if (rst_x) begin
      state_reg    <= ST_IDLE;
      src_reg      <= SRC_RST;
      vec_reg      <= VEC_RST;
      rst_pend_reg <= 1'b1;
      nmi_pend_reg <= 1'b0;
      set_b_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      src_reg      <= src_next;
      vec_reg      <= vec_next;
      rst_pend_reg <= rst_pend_next;
      nmi_pend_reg <= nmi_pend_next;
      set_b_reg    <= set_b_next;
    end
  end

  // Next-state, memory request and register-file strobe generation.
  always_comb begin
    state_next    = state_reg;
    src_next      = src_reg;
    vec_next      = vec_reg;
    rst_pend_next = rst_pend_reg;
    nmi_pend_next = nmi_pend_reg;
    set_b_next    = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 16'h0000;
    mem_wdata     = 8'h00;
    intr_data     = 8'h00;
    intr_set_pcl  = 1'b0;
    intr_set_pch  = 1'b0;
    intr_set_i    = 1'b0;
    intr_pushed   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (rst_pend_reg) begin
          // Reset entry skips the pushes; S is left alone.
          rst_pend_next = 1'b0;
          src_next      = SRC_RST;
          vec_next      = VEC_RST;
          state_next    = ST_VEC_LO;
        end else if (exec_boundary) begin
          if (exec_brk) begin
            src_next   = SRC_BRK;
            vec_next   = VEC_IRQ;
            set_b_next = 1'b1;
            state_next = ST_PUSH_PCH;
          end else if (nmi_pend_reg) begin
            src_next   = SRC_NMI;
            vec_next   = VEC_NMI;
            state_next = ST_PUSH_PCH;
          end else if (irq && !rf_psr[2]) begin
            src_next   = SRC_IRQ;
            vec_next   = VEC_IRQ;
            state_next = ST_PUSH_PCH;
          end
        end
      end

      ST_PUSH_PCH: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {8'h01, rf_s};
        mem_wdata = rf_pc[15:8];
        if (mem_ack) begin
          intr_pushed = 1'b1;
          state_next  = ST_PUSH_PCL;
        end
      end

      ST_PUSH_PCL: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {8'h01, rf_s};
        mem_wdata = rf_pc[7:0];
        if (mem_ack) begin
          intr_pushed = 1'b1;
          state_next  = ST_PUSH_PSR;
        end
      end

      ST_PUSH_PSR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {8'h01, rf_s};
        mem_wdata = psr_push;
        if (mem_ack) begin
          intr_pushed = 1'b1;
          state_next  = ST_VEC_LO;
`ifdef INTR_NMI_HIJACK_EN
          // A pending NMI steals the vector; the already-pushed B bit stays.
          if (nmi_pend_reg) begin
            vec_next = VEC_NMI;
          end
`else
          vec_next = vec_reg;
`endif
        end
      end

      ST_VEC_LO: begin
        mem_req  = 1'b1;
        mem_addr = vec_reg;
        if (mem_ack) begin
          intr_data    = mem_rdata;
          intr_set_pcl = 1'b1;
          if (vec_reg == VEC_NMI) begin
            nmi_pend_next = 1'b0;
          end
          state_next = ST_VEC_HI;
        end
      end

      ST_VEC_HI: begin
        mem_req  = 1'b1;
        mem_addr = vec_reg | 16'h0001;
        if (mem_ack) begin
          intr_data    = mem_rdata;
          intr_set_pch = 1'b1;
          intr_set_i   = 1'b1;
          state_next   = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A fresh edge wins over a same-cycle clear so it is never lost.
    if (nmi_rise) begin
      nmi_pend_next = 1'b1;
    end
  end

  assign intr_set_b = set_b_reg;
  assign intr_busy  = (state_reg != ST_IDLE) | rst_pend_reg;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: a memory responder with
// programmable wait states, a tiny register-file model, and a reference
// model that lists the expected memory transactions of each entry sequence.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst_x = 1'b1;
  logic        nmi = 1'b0;
  logic        irq = 1'b0;
  logic        exec_brk = 1'b0;
  logic        exec_boundary = 1'b1;
  logic [15:0] rf_pc = 16'h0000;
  logic [7:0]  rf_psr = 8'h00;
  logic [7:0]  rf_s = 8'hFF;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic [7:0]  intr_data;
  logic        intr_set_pcl, intr_set_pch, intr_set_i, intr_set_b, intr_pushed, intr_busy;

  always #5 clk = ~clk;

  interrupt_sequencer dut (
    .clk(clk), .rst_x(rst_x), .nmi(nmi), .irq(irq), .exec_brk(exec_brk),
    .exec_boundary(exec_boundary), .rf_pc(rf_pc), .rf_psr(rf_psr), .rf_s(rf_s),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .intr_data(intr_data),
    .intr_set_pcl(intr_set_pcl), .intr_set_pch(intr_set_pch), .intr_set_i(intr_set_i),
    .intr_set_b(intr_set_b), .intr_pushed(intr_pushed), .intr_busy(intr_busy)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } txn_t;

  localparam int SRC_IRQ = 0, SRC_BRK = 1, SRC_NMI = 2, SRC_RST = 3;

  txn_t        txq[$];
  txn_t        exp_q[$];
  txn_t        mon_t;
  logic [7:0]  mem_model [0:65535];
  logic        busy_hist [0:16383];
  int          cyc = 0, waits = 0, wait_cnt = 0;
  int          pushed_cnt = 0, pcl_cnt = 0, pch_cnt = 0, setb_cnt = 0, viol_cnt = 0;
  int          pch_cyc = 0, setb_cyc = 0;
  logic [7:0]  last_pcl = 8'h00, last_pch = 8'h00;
  logic        pend_valid = 1'b0, p_we = 1'b0;
  logic [15:0] p_addr = 16'h0000;
  logic [7:0]  p_wdata = 8'h00;
  int          errors = 0, checks = 0;

  // Memory responder + monitor: ack decided at negedge, everything sampled 1 later.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_req && wait_cnt >= waits) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_we ? 8'h00 : mem_model[mem_addr];
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
    end
    #1;
    busy_hist[cyc & 16383] = intr_busy;
    if (rst_x) begin
      pend_valid = 1'b0;
    end else begin
      if (pend_valid && (mem_req !== 1'b1 || mem_we !== p_we || mem_addr !== p_addr ||
                         (p_we && mem_wdata !== p_wdata)))
        viol_cnt++;
      if (mem_req && !mem_ack) begin
        pend_valid = 1'b1; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
      end else begin
        pend_valid = 1'b0;
      end
    end
    if (mem_req && !mem_ack) wait_cnt++;
    else wait_cnt = 0;
    if (mem_req && mem_ack) begin
      mon_t.we   = mem_we;
      mon_t.addr = mem_addr;
      mon_t.data = mem_we ? mem_wdata : mem_rdata;
      mon_t.cyc  = cyc;
      txq.push_back(mon_t);
      if (mem_we) mem_model[mem_addr] = mem_wdata;
    end
    if ((intr_set_pcl || intr_set_pch || intr_set_i || intr_pushed) && !mem_ack) viol_cnt++;
    if (intr_set_pch !== intr_set_i) viol_cnt++;
    if (intr_pushed) begin pushed_cnt++; rf_s = rf_s - 8'd1; end
    if (intr_set_pcl) begin pcl_cnt++; last_pcl = intr_data; rf_pc[7:0] = intr_data; end
    if (intr_set_pch) begin pch_cnt++; last_pch = intr_data; pch_cyc = cyc; rf_pc[15:8] = intr_data; end
    if (intr_set_i) rf_psr = rf_psr | 8'h04;
    if (intr_set_b) begin setb_cnt++; setb_cyc = cyc; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    txq.delete();
    exp_q.delete();
    pushed_cnt = 0; pcl_cnt = 0; pch_cnt = 0; setb_cnt = 0; viol_cnt = 0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    bit seen;
    seen = 0;
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #2;
      if (intr_busy) seen = 1;
      else if (seen) begin ok = 1; break; end
    end
  endtask

  // Reference: what an entry sequence must put on the memory port.
  task automatic build_exp(input int src, input logic [15:0] pc, input logic [7:0] s,
                           input logic [7:0] psr, input logic [15:0] vec);
    txn_t t;
    t.cyc = 0;
    if (src != SRC_RST) begin
      t.we = 1'b1;
      t.addr = {8'h01, s};          t.data = pc[15:8];  exp_q.push_back(t);
      t.addr = {8'h01, s - 8'd1};   t.data = pc[7:0];   exp_q.push_back(t);
      t.addr = {8'h01, s - 8'd2};
      t.data = psr | 8'h20 | ((src == SRC_BRK) ? 8'h10 : 8'h00);
      exp_q.push_back(t);
    end
    t.we = 1'b0;
    t.addr = vec;          t.data = mem_model[vec];          exp_q.push_back(t);
    t.addr = vec + 16'd1;  t.data = mem_model[vec + 16'd1];  exp_q.push_back(t);
  endtask

  task automatic test_reset();
    bit ok;
    int c0;
    clear_log();
    waits = 0;
    rst_x = 1'b1;
    step();
    step();
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || intr_busy !== 1'b1 || intr_set_b !== 1'b0 ||
        intr_set_pcl !== 1'b0 || intr_set_pch !== 1'b0 || intr_pushed !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got req=%0b we=%0b busy=%0b setb=%0b, want req=0 we=0 busy=1 setb=0",
               mem_req, mem_we, intr_busy, intr_set_b);
    end
    mem_model[16'hFFFC] = 8'hEF;
    mem_model[16'hFFFD] = 8'hBE;
    rst_x = 1'b0;
    c0 = cyc + 1;
    wait_idle(30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_timeout: got busy still high, want idle"); end
    build_exp(SRC_RST, 16'h0000, 8'h00, 8'h00, 16'hFFFC);
    checks++;
    if (txq.size() != exp_q.size()) begin
      errors++; $display("FAIL reset_count: got %0d txns, want %0d", txq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      checks++;
      if (txq[i].we !== exp_q[i].we || txq[i].addr !== exp_q[i].addr || txq[i].data !== exp_q[i].data ||
          txq[i].cyc != c0 + 1 + i) begin
        errors++;
        $display("FAIL reset_txn%0d: got we=%0b addr=%h data=%h cyc=%0d, want we=%0b addr=%h data=%h cyc=%0d",
                 i, txq[i].we, txq[i].addr, txq[i].data, txq[i].cyc,
                 exp_q[i].we, exp_q[i].addr, exp_q[i].data, c0 + 1 + i);
      end
    end
    checks++;
    if (last_pcl !== 8'hEF || last_pch !== 8'hBE || pcl_cnt != 1 || pch_cnt != 1 || pushed_cnt != 0) begin
      errors++;
      $display("FAIL reset_load: got pcl=%h pch=%h npcl=%0d npch=%0d pushes=%0d, want EF BE 1 1 0",
               last_pcl, last_pch, pcl_cnt, pch_cnt, pushed_cnt);
    end
    checks++;
    if (viol_cnt != 0) begin errors++; $display("FAIL reset_protocol: got %0d violations, want 0", viol_cnt); end
    $display("reset: vector fetch %0d txns, pc=%h", txq.size(), rf_pc);
  endtask

  task automatic test_irq();
    bit ok;
    int c0;
    clear_log();
    waits = 0;
    mem_model[16'hFFFE] = 8'h78;
    mem_model[16'hFFFF] = 8'h56;
    step();
    rf_pc = 16'h1234; rf_s = 8'hFD; rf_psr = 8'h00;
    irq = 1'b1;
    c0 = cyc + 1;
    step();
    irq = 1'b0;
    wait_idle(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL irq_timeout: got busy stuck, want idle"); end
    build_exp(SRC_IRQ, 16'h1234, 8'hFD, 8'h00, 16'hFFFE);
    checks++;
    if (txq.size() != exp_q.size()) begin
      errors++; $display("FAIL irq_count: got %0d txns, want %0d", txq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      checks++;
      if (txq[i].we !== exp_q[i].we || txq[i].addr !== exp_q[i].addr || txq[i].data !== exp_q[i].data ||
          txq[i].cyc != c0 + 1 + i) begin
        errors++;
        $display("FAIL irq_txn%0d: got we=%0b addr=%h data=%h cyc=%0d, want we=%0b addr=%h data=%h cyc=%0d",
                 i, txq[i].we, txq[i].addr, txq[i].data, txq[i].cyc,
                 exp_q[i].we, exp_q[i].addr, exp_q[i].data, c0 + 1 + i);
      end
    end
    checks++;
    if (pushed_cnt != 3 || pch_cyc != c0 + 5 || last_pcl !== 8'h78 || last_pch !== 8'h56 || setb_cnt != 0) begin
      errors++;
      $display("FAIL irq_pulses: got pushes=%0d pch_cyc=%0d pcl=%h pch=%h setb=%0d, want 3 %0d 78 56 0",
               pushed_cnt, pch_cyc, last_pcl, last_pch, setb_cnt, c0 + 5);
    end
    for (int k = 0; k <= 6; k++) begin
      checks++;
      if (busy_hist[(c0 + k) & 16383] !== ((k >= 1 && k <= 5) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL irq_busy_c%0d: got %0b, want %0b", k, busy_hist[(c0 + k) & 16383],
                 (k >= 1 && k <= 5));
      end
    end
    checks++;
    if (viol_cnt != 0) begin errors++; $display("FAIL irq_protocol: got %0d violations, want 0", viol_cnt); end
    $display("irq: %0d txns, pch in cycle +%0d", txq.size(), pch_cyc - c0);
  endtask

  task automatic test_masked_irq();
    clear_log();
    step();
    rf_psr = 8'h04;
    irq = 1'b1;
    exec_boundary = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k == 10) begin rf_psr = 8'h00; exec_boundary = 1'b0; end
      step();
      checks++;
      if (mem_req !== 1'b0 || intr_busy !== 1'b0) begin
        errors++;
        $display("FAIL masked_irq_c%0d: got req=%0b busy=%0b, want 0 0", k, mem_req, intr_busy);
      end
    end
    irq = 1'b0;
    exec_boundary = 1'b1;
    $display("masked_irq: %0d txns while masked / off-boundary", txq.size());
  endtask

  task automatic test_brk();
    bit ok;
    clear_log();
    waits = 0;
    mem_model[16'hFFFE] = 8'h9A;
    mem_model[16'hFFFF] = 8'hBC;
    step();
    rf_pc = 16'hC0DE; rf_s = 8'hF0; rf_psr = 8'h00;
    exec_brk = 1'b1;
    step();
    exec_brk = 1'b0;
    wait_idle(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL brk_timeout: got busy stuck, want idle"); end
    build_exp(SRC_BRK, 16'hC0DE, 8'hF0, 8'h00, 16'hFFFE);
    checks++;
    if (txq.size() != exp_q.size()) begin
      errors++; $display("FAIL brk_count: got %0d txns, want %0d", txq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      checks++;
      if (txq[i].we !== exp_q[i].we || txq[i].addr !== exp_q[i].addr || txq[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL brk_txn%0d: got we=%0b addr=%h data=%h, want we=%0b addr=%h data=%h",
                 i, txq[i].we, txq[i].addr, txq[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (setb_cnt != 1 || txq.size() == 0 || setb_cyc != txq[0].cyc) begin
      errors++;
      $display("FAIL brk_setb: got pulses=%0d cyc=%0d, want 1 pulse in first push cycle", setb_cnt, setb_cyc);
    end
    checks++;
    if (viol_cnt != 0) begin errors++; $display("FAIL brk_protocol: got %0d violations, want 0", viol_cnt); end
    $display("brk: %0d txns, set_b pulses %0d", txq.size(), setb_cnt);
  endtask

  task automatic test_nmi_during_irq();
    bit ok, found;
    clear_log();
    waits = 2;
    mem_model[16'hFFFA] = 8'h11; mem_model[16'hFFFB] = 8'h22;
    mem_model[16'hFFFE] = 8'h33; mem_model[16'hFFFF] = 8'h44;
    step();
    rf_pc = 16'hA5C3; rf_s = 8'h80; rf_psr = 8'h00;
    irq = 1'b1;
    step();
    irq = 1'b0;
    found = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #2;
      if (txq.size() == 1 && mem_req) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL nmi_find_pcl: got no PUSH_PCL, want one"); end
    nmi = 1'b1;
    @(negedge clk);
    #2;
    nmi = 1'b0;
    wait_idle(80, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nmi_timeout1: got busy stuck, want idle"); end
`ifdef INTR_NMI_HIJACK_EN
    build_exp(SRC_IRQ, 16'hA5C3, 8'h80, 8'h00, 16'hFFFA);
    repeat (10) step();
    checks++;
    if (mem_req !== 1'b0 || intr_busy !== 1'b0 || pushed_cnt != 3) begin
      errors++;
      $display("FAIL nmi_hijack_after: got req=%0b busy=%0b pushes=%0d, want 0 0 3", mem_req, intr_busy, pushed_cnt);
    end
`else
    wait_idle(80, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nmi_timeout2: got no second sequence, want NMI entry"); end
    build_exp(SRC_IRQ, 16'hA5C3, 8'h80, 8'h00, 16'hFFFE);
    build_exp(SRC_NMI, 16'h4433, 8'h80 - 8'd3, 8'h04, 16'hFFFA);
    checks++;
    if (pushed_cnt != 6) begin errors++; $display("FAIL nmi_pushes: got %0d, want 6", pushed_cnt); end
`endif
    checks++;
    if (txq.size() != exp_q.size()) begin
      errors++; $display("FAIL nmi_count: got %0d txns, want %0d", txq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      checks++;
      if (txq[i].we !== exp_q[i].we || txq[i].addr !== exp_q[i].addr || txq[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL nmi_txn%0d: got we=%0b addr=%h data=%h, want we=%0b addr=%h data=%h",
                 i, txq[i].we, txq[i].addr, txq[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (viol_cnt != 0) begin errors++; $display("FAIL nmi_protocol: got %0d violations, want 0", viol_cnt); end
    waits = 0;
    $display("nmi_during_irq: %0d txns, final pc=%h", txq.size(), rf_pc);
  endtask

  task automatic test_reset_mid();
    bit ok, found;
    clear_log();
    waits = 1;
    mem_model[16'hFFFC] = 8'h5A;
    mem_model[16'hFFFD] = 8'hC3;
    step();
    rf_pc = 16'h0F0F; rf_s = 8'h40; rf_psr = 8'h00;
    irq = 1'b1;
    step();
    irq = 1'b0;
    found = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #2;
      if (txq.size() == 2 && mem_req && !mem_ack) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_find_psr: got no PUSH_PSR, want one"); end
    rst_x = 1'b1;
    step();
    checks++;
    if (mem_req !== 1'b0 || intr_busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_abort: got req=%0b busy=%0b, want 0 1", mem_req, intr_busy);
    end
    step();
    checks++;
    if (txq.size() != 2) begin errors++; $display("FAIL rstmid_psr_dropped: got %0d writes, want 2", txq.size()); end
    rst_x = 1'b0;
    clear_log();
    wait_idle(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_timeout: got busy stuck, want idle"); end
    build_exp(SRC_RST, 16'h0000, 8'h00, 8'h00, 16'hFFFC);
    checks++;
    if (txq.size() != exp_q.size() || pushed_cnt != 0) begin
      errors++; $display("FAIL rstmid_count: got %0d txns %0d pushes, want %0d 0", txq.size(), pushed_cnt, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      checks++;
      if (txq[i].we !== exp_q[i].we || txq[i].addr !== exp_q[i].addr || txq[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL rstmid_txn%0d: got we=%0b addr=%h data=%h, want we=%0b addr=%h data=%h",
                 i, txq[i].we, txq[i].addr, txq[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
      end
    end
    waits = 0;
    $display("reset_mid: restart fetched pc=%h", rf_pc);
  endtask

  task automatic test_random();
    bit ok;
    int src;
    logic [15:0] pc, vec;
    logic [7:0] s, psr;
    for (int it = 0; it < 20; it++) begin
      clear_log();
      waits = $urandom_range(0, 3);
      src = $urandom_range(0, 2);
      pc = 16'($urandom);
      s = 8'($urandom);
      psr = 8'($urandom);
      if (src == SRC_IRQ) psr[2] = 1'b0;
      for (int k = 0; k < 6; k++) mem_model[16'hFFFA + 16'(k)] = 8'($urandom);
      vec = (src == SRC_NMI) ? 16'hFFFA : 16'hFFFE;
      step();
      rf_pc = pc; rf_s = s; rf_psr = psr;
      if (src == SRC_IRQ) irq = 1'b1;
      else if (src == SRC_BRK) exec_brk = 1'b1;
      else nmi = 1'b1;
      step();
      irq = 1'b0;
      exec_brk = 1'b0;
      wait_idle(80, ok);
      nmi = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL rand%0d_timeout: got busy stuck, want idle", it); end
      build_exp(src, pc, s, psr, vec);
      checks++;
      if (txq.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d txns, want %0d", it, txq.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
        checks++;
        if (txq[i].we !== exp_q[i].we || txq[i].addr !== exp_q[i].addr || txq[i].data !== exp_q[i].data) begin
          errors++;
          $display("FAIL rand%0d_txn%0d: got we=%0b addr=%h data=%h, want we=%0b addr=%h data=%h",
                   it, i, txq[i].we, txq[i].addr, txq[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
        end
      end
      checks++;
      if (pushed_cnt != 3 || last_pcl !== mem_model[vec] || last_pch !== mem_model[vec + 16'd1] ||
          setb_cnt != ((src == SRC_BRK) ? 1 : 0) || viol_cnt != 0) begin
        errors++;
        $display("FAIL rand%0d_pulses: got pushes=%0d pcl=%h pch=%h setb=%0d viol=%0d, want 3 %h %h %0d 0",
                 it, pushed_cnt, last_pcl, last_pch, setb_cnt, viol_cnt,
                 mem_model[vec], mem_model[vec + 16'd1], (src == SRC_BRK));
      end
      $display("random %0d: src=%0d waits=%0d pc=%h s=%h psr=%h -> %0d txns", it, src, waits, pc, s, psr, txq.size());
    end
  endtask

  initial begin
    test_reset();
    test_irq();
    test_masked_irq();
    test_brk();
    test_nmi_during_irq();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Interrupt/reset sequencer for the 6502 core. It is the writer side of the register file's `intr_*` port group. It detects reset, NMI, IRQ and BRK; pushes PCH, PCL and PSR onto the stack through the memory port; and fetches the 16-bit vector. It loads that vector into PC through `intr_set_pcl`/`intr_set_pch` and sets the I flag. It sits between the memory controller, the execution unit and the register file, and stalls the core through `intr_busy` while a sequence runs.

## Interface
- No parameters.
- `clk  in  1`  system clock; all state changes on rising edge.
- `rst_x  in  1`  synchronous, active-high reset.
- `nmi  in  1`  NMI request, active-high, rising-edge sensitive.
- `irq  in  1`  IRQ request, active-high, level sensitive.
- `exec_brk  in  1`  one-cycle pulse: execution unit has decoded BRK.
- `exec_boundary  in  1`  core is at an instruction boundary.
- `rf_pc  in  16`  current PC from register file.
- `rf_psr  in  8`  current PSR from register file.
- `rf_s  in  8`  current stack pointer.
- `mem_req  out  1`  memory request, held until `mem_ack`.
- `mem_we  out  1`  1 = write (push), 0 = read (vector).
- `mem_addr  out  16`  address.
- `mem_wdata  out  8`  write data.
- `mem_rdata  in  8`  read data, valid with `mem_ack`.
- `mem_ack  in  1`  transaction complete this cycle.
- `intr_data  out  8`  data for PCL/PCH load.
- `intr_set_pcl  out  1`  load `intr_data` into PC[7:0].
- `intr_set_pch  out  1`  load `intr_data` into PC[15:8].
- `intr_set_i  out  1`  set I flag.
- `intr_set_b  out  1`  set B flag.
- `intr_pushed  out  1`  one push completed; register file decrements S.
- `intr_busy  out  1`  sequence in progress; core stalls.

## Operation
- States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_PSR, VEC_LO, VEC_HI.
- NMI edge detector: register `nmi`.
  - Rising edge sets `nmi_pend`.
  - `nmi_pend` clears on the VEC_LO ack that fetches $FFFA.
- Accept from IDLE (only when `exec_boundary`=1), priority high to low:
  - `exec_brk` → source BRK.
  - `nmi_pend` → source NMI.
  - `irq` && !`rf_psr[2]` → source IRQ.
  - The selected source is latched, and the sequence goes to PUSH_PCH.
- Push states, stack address {8'h01, `rf_s`}, `mem_we`=1:
  - PUSH_PCH writes `rf_pc[15:8]`.
  - PUSH_PCL writes `rf_pc[7:0]`.
  - PUSH_PSR writes `rf_psr | 8'h20`, also OR 8'h10 when the source is BRK.
- Each push ack: `intr_pushed`=1 for that cycle, and the state advances. The updated `rf_s` is visible on the next push.
- Vector selection: NMI → $FFFA, reset → $FFFC, IRQ/BRK → $FFFE.
- VEC_LO:
  - Reads vector; on ack, `intr_data`=`mem_rdata` and `intr_set_pcl`=1.
- VEC_HI:
  - Reads vector+1; on ack, `intr_data`=`mem_rdata`, and `intr_set_pch`=1 and `intr_set_i`=1.
  - Then returns to IDLE.
- `intr_set_b`: one-cycle pulse on the BRK accept edge's following cycle (first PUSH_PCH cycle).
- Reset sequence: the first cycle after `rst_x` falls starts VEC_LO with vector $FFFC. No pushes; S is untouched.

## Timing
- Reset values (while `rst_x`=1 and on the following edge): state IDLE-with-reset-pending, `nmi_pend`=0, all outputs 0 except `intr_busy`=1.
- Reset mid-sequence aborts immediately. `mem_req` drops in the first cycle `rst_x` is sampled high.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable from the first cycle of a state until the `mem_ack` cycle inclusive.
- `mem_ack` may arrive in the same cycle as `mem_req` (zero-wait memory).
- Zero-wait latency, IRQ: accept edge at end of cycle 0.
  - Pushes in cycles 1–3, VEC_LO in cycle 4, VEC_HI in cycle 5 (`intr_set_pch`).
  - `intr_busy` is 0 in cycle 6.
- `intr_busy`=1 in every non-IDLE cycle and in the accept cycle's successor onward.
- `intr_set_*` and `intr_pushed` are single-cycle pulses, never asserted without `mem_ack`, except `intr_set_b`.
- An NMI edge during a sequence is latched and serviced at the next boundary.
- `irq` deasserted after accept does not cancel the sequence.

## Configuration
- `INTR_NMI_HIJACK_EN` defined: if `nmi_pend` is set at VEC_LO entry during a BRK or IRQ sequence, the vector becomes $FFFA and `nmi_pend` clears. The pushed B bit is unchanged.
- Undefined: the vector is fixed at accept time.

## Test plan
- Reset: `rst_x` high 2 cycles then low; memory returns $EF at $FFFC and $BE at $FFFD → `intr_set_pcl` with $EF, then `intr_set_pch` with $BE and `intr_set_i`; no `mem_we`.
- IRQ: `rf_pc`=$1234, `rf_s`=$FD, `rf_psr`=$00, `irq`=1 at boundary → writes $12@$01FD, $34@$01FC, $20@$01FB; reads $FFFE/$FFFF; three `intr_pushed` pulses.
- Masked IRQ: `rf_psr`=$04, `irq`=1 for 10 cycles → `mem_req` stays 0 and `intr_busy` stays 0.
- BRK: `exec_brk` pulse with `rf_psr`=$00 → `intr_set_b` pulse; PSR push writes $30; vector read at $FFFE.
- NMI during IRQ pushes: NMI edge in PUSH_PCL with a 2-wait memory → with the macro, vector $FFFA; without it, vector $FFFE and a second sequence to $FFFA follows.
- Reset mid-sequence: assert `rst_x` during PUSH_PSR → `mem_req` drops; after release, the $FFFC fetch restarts.
